// File: rtl/touch_int_pkg.sv
// Shared types and constants for the touch interrupt conditioner.
// Optional event counter is enabled by defining TOUCH_INT_EVENT_COUNT_EN.
`timescale 1ns/1ps
package touch_int_pkg;

   typedef enum logic [1:0] {
      IDLE,
      QUALIFY,
      ASSERT,
      RELEASE
   } state_e;

   localparam int EVT_W = 16;
   localparam logic [EVT_W-1:0] EVT_MAX = 16'hFFFF;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/touch_int_sync.sv
// Two-flop synchronizer for the raw pad; resets to the idle (high) level.
`timescale 1ns/1ps
module touch_int_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/touch_int_conditioner.sv
// Synchronize, glitch-filter and stretch the active-low touch interrupt.
// Define TOUCH_INT_EVENT_COUNT_EN to add event_clr/event_count.
`timescale 1ns/1ps
module touch_int_conditioner
   import touch_int_pkg::*;
#(
   parameter int FILTER_CYCLES  = 4,
   parameter int MIN_LOW_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic touch_int_n_raw,
   output logic int_n_clean,
   output logic glitch_pulse
`ifdef TOUCH_INT_EVENT_COUNT_EN
  ,input  logic             event_clr,
   output logic [EVT_W-1:0] event_count
`endif
);

   localparam int CW = $clog2(max_int(FILTER_CYCLES, MIN_LOW_CYCLES) + 1);
   localparam logic [CW-1:0] FLT_LAST  = CW'(FILTER_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(MIN_LOW_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   if (FILTER_CYCLES < 2) begin : g_bad_filter
      $error("FILTER_CYCLES must be >= 2");
   end
   if (MIN_LOW_CYCLES < 1) begin : g_bad_hold
      $error("MIN_LOW_CYCLES must be >= 1");
   end

   logic sync;

   touch_int_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (touch_int_n_raw),
      .q     (sync)
   );

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          clean_q, clean_d;
   logic          glitch_q, glitch_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      clean_d  = clean_q;
      glitch_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            clean_d = 1'b1;
            if (!sync) begin
               state_d = QUALIFY;
               cnt_d   = CNT_ONE;
            end
         end
         QUALIFY: begin
            if (sync) begin
               state_d  = IDLE;
               glitch_d = 1'b1;
            end else if (cnt_q == FLT_LAST) begin
               state_d = ASSERT;
               clean_d = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         // Early release is ignored until the minimum low time has elapsed.
         ASSERT: begin
            clean_d = 1'b0;
            if (cnt_q != HOLD_LAST) begin
               cnt_d = cnt_q + CNT_ONE;
            end else if (sync) begin
               state_d = RELEASE;
               cnt_d   = CNT_ONE;
            end
         end
         RELEASE: begin
            clean_d = 1'b0;
            if (!sync) begin
               state_d  = ASSERT;
               cnt_d    = HOLD_LAST;
               glitch_d = 1'b1;
            end else if (cnt_q == FLT_LAST) begin
               state_d = IDLE;
               clean_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            clean_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         clean_q  <= 1'b1;
         glitch_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         clean_q  <= clean_d;
         glitch_q <= glitch_d;
      end
   end

   assign int_n_clean  = clean_q;
   assign glitch_pulse = glitch_q;

`ifdef TOUCH_INT_EVENT_COUNT_EN
   logic             evt_inc;
   logic [EVT_W-1:0] evt_q, evt_d;

   assign evt_inc = (state_q == QUALIFY) && (state_d == ASSERT);

   // A clear coinciding with an accepted event leaves a count of one.
   always_comb begin
      evt_d = evt_q;
      if (event_clr) begin
         evt_d = evt_inc ? {{(EVT_W-1){1'b0}}, 1'b1} : '0;
      end else if (evt_inc && evt_q != EVT_MAX) begin
         evt_d = evt_q + {{(EVT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) evt_q <= '0;
      else       evt_q <= evt_d;
   end

   assign event_count = evt_q;
`endif

endmodule

// File: tb/tb_touch_int_conditioner.sv
// Directed self-checking bench for touch_int_conditioner (FILTER=4, MIN_LOW=16).
// Covers the event counter too when TOUCH_INT_EVENT_COUNT_EN is defined.
`timescale 1ns/1ps
module tb_touch_int_conditioner;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic raw = 1'b1;
   logic int_n_clean;
   logic glitch_pulse;
`ifdef TOUCH_INT_EVENT_COUNT_EN
   logic        event_clr = 1'b0;
   logic [15:0] event_count;
`endif

   int checks = 0;
   int fails  = 0;

   always #10 clk = ~clk;

   touch_int_conditioner #(
      .FILTER_CYCLES  (4),
      .MIN_LOW_CYCLES (16)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .touch_int_n_raw (raw),
      .int_n_clean     (int_n_clean),
      .glitch_pulse    (glitch_pulse)
`ifdef TOUCH_INT_EVENT_COUNT_EN
     ,.event_clr       (event_clr),
      .event_count     (event_count)
`endif
   );

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // pat[k-1] is the raw level sampled at edge k; outputs sampled 1ns after.
   task automatic run(input int n, input logic [63:0] pat,
                      output int fall, output int rise, output int lows,
                      output int gls, output int gedge, output int nfalls);
      logic prev;
      fall = 0; rise = 0; lows = 0; gls = 0; gedge = 0; nfalls = 0;
      prev = int_n_clean;
      for (int k = 1; k <= n; k++) begin
         raw = pat[k-1];
         @(posedge clk);
         #1;
         if (!int_n_clean) lows++;
         if (prev && !int_n_clean) begin
            nfalls++;
            if (fall == 0) fall = k;
         end
         if (!prev && int_n_clean && rise == 0) rise = k;
         if (glitch_pulse) begin
            gls++;
            if (gedge == 0) gedge = k;
         end
         prev = int_n_clean;
      end
   endtask

   int fall, rise, lows, gls, gedge, nfalls;
   logic [63:0] p;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_clean", int_n_clean, 1);
      chk("rst_glitch", glitch_pulse, 0);
`ifdef TOUCH_INT_EVENT_COUNT_EN
      chk("rst_count", event_count, 0);
`endif
      reset = 1'b0;

      // 1: three-clock low glitch is rejected
      p = ~64'h7;
      run(14, p, fall, rise, lows, gls, gedge, nfalls);
      chk("t1_lows", lows, 0);
      chk("t1_glitches", gls, 1);
      chk("t1_glitch_edge", gedge, 6);
`ifdef TOUCH_INT_EVENT_COUNT_EN
      chk("t1_count", event_count, 0);
`endif

      // 2: long touch, 40 clocks low
      p = ~((64'h1 << 40) - 64'h1);
      run(52, p, fall, rise, lows, gls, gedge, nfalls);
      chk("t2_fall_edge", fall, 6);
      chk("t2_rise_edge", rise, 46);
      chk("t2_glitches", gls, 0);
`ifdef TOUCH_INT_EVENT_COUNT_EN
      chk("t2_count", event_count, 1);
`endif

      // 3: short touch is stretched to the minimum low time
      p = ~64'h1F;
      run(30, p, fall, rise, lows, gls, gedge, nfalls);
      chk("t3_fall_edge", fall, 6);
      chk("t3_rise_edge", rise, 25);
      chk("t3_low_clocks", lows, 19);
`ifdef TOUCH_INT_EVENT_COUNT_EN
      chk("t3_count", event_count, 2);
`endif

      // 4: low blip during release filter re-enters ASSERT
      p = ~(((64'h1 << 40) - 64'h1) | (64'h3 << 42));
      run(60, p, fall, rise, lows, gls, gedge, nfalls);
      chk("t4_falls", nfalls, 1);
      chk("t4_glitches", gls, 1);
      chk("t4_glitch_edge", gedge, 45);
      chk("t4_rise_edge", rise, 50);
`ifdef TOUCH_INT_EVENT_COUNT_EN
      chk("t4_count", event_count, 3);
`endif

      // 5: async reset while asserted
      p = 64'h0;
      run(8, p, fall, rise, lows, gls, gedge, nfalls);
      chk("t5_pre_low", int_n_clean, 0);
      #4;
      reset = 1'b1;
      #1;
      chk("t5_async_clean", int_n_clean, 1);
      chk("t5_async_glitch", glitch_pulse, 0);
`ifdef TOUCH_INT_EVENT_COUNT_EN
      chk("t5_count", event_count, 0);
`endif
      repeat (2) @(posedge clk);
      #1;
      raw = 1'b1;
      reset = 1'b0;
      p = ~64'h0;
      run(10, p, fall, rise, lows, gls, gedge, nfalls);
      chk("t5_post_lows", lows, 0);
      chk("t5_post_glitches", gls, 0);

`ifdef TOUCH_INT_EVENT_COUNT_EN
      // 6: saturation and clear-on-increment
      @(negedge clk);
      force dut.evt_q = 16'hFFFE;
      @(negedge clk);
      release dut.evt_q;
      #1;
      chk("t6_preload", event_count, 16'hFFFE);
      p = ~64'h1F;
      for (int e = 0; e < 3; e++) begin
         run(30, p, fall, rise, lows, gls, gedge, nfalls);
      end
      chk("t6_saturate", event_count, 16'hFFFF);
      for (int k = 1; k <= 30; k++) begin
         raw = (k <= 5) ? 1'b0 : 1'b1;
         event_clr = (k == 6);
         @(posedge clk);
         #1;
         event_clr = 1'b0;
      end
      chk("t6_clr_on_inc", event_count, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
